// File: rtl/dft_octave_control.sv
`default_nettype none
// ============================================================================
// Module      : dft_octave_control
// Description : Sequencer and per-octave sample delay lines for a multi-octave
//               sliding DFT. Accepts one sample per handshake, stores it into
//               the octaves enabled by the decimation selector, then walks the
//               downstream arithmetic through every (octave, add/sub, bin)
//               slot with the selected octave's taps muxed out.
// Revision    : 1.0 - initial release
// ============================================================================
module dft_octave_control #(
  parameter int OCT  = 5,
  parameter int BINS = 24,
  parameter int N    = 16,
  parameter int SIZE = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sampleReady,
  input  logic signed [N-1:0]       newSample,
  output logic                      ready,
  output logic                      writeSample,
  output logic [$clog2(OCT)-1:0]    octave,
  output logic                      operation,
  output logic [$clog2(BINS)-1:0]   bin,
  output logic                      finishedProcessing,
  output logic [OCT-1:0]            enableOctaves,
  output logic signed [N-1:0]       sample0,
  output logic signed [N-1:0]       sample1,
  output logic signed [N-1:0]       oldestSample
);

  localparam int c_OW = $clog2(OCT);
  localparam int c_BW = $clog2(BINS);
  localparam int c_CW = OCT - 1;

  localparam logic [c_OW-1:0] c_LAST_OCT = c_OW'(OCT - 1);
  localparam logic [c_BW-1:0] c_LAST_BIN = c_BW'(BINS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_PROCESS = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  logic [c_CW-1:0]   r_sel;

  // Tap wires gathered from each octave's delay line
  logic [OCT-1:0][N-1:0] w_tap0;
  logic [OCT-1:0][N-1:0] w_tap1;
  logic [OCT-1:0][N-1:0] w_tapo;

  // Sequencer: IDLE -> WRITE -> PROCESS (all slots) -> DONE -> IDLE, outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= S_IDLE;
      ready              <= 1'b1;
      writeSample        <= 1'b0;
      finishedProcessing <= 1'b0;
      octave             <= '0;
      bin                <= '0;
      operation          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sampleReady) begin
            r_state     <= S_WRITE;
            ready       <= 1'b0;
            writeSample <= 1'b1;
          end
        end
        S_WRITE: begin
          writeSample <= 1'b0;
          r_state     <= S_PROCESS;
        end
        S_PROCESS: begin
          if (bin == c_LAST_BIN) begin
            bin <= '0;
            if (operation) begin
              operation <= 1'b0;
              if (octave == c_LAST_OCT) begin
                octave             <= '0;
                finishedProcessing <= 1'b1;
                r_state            <= S_DONE;
              end else begin
                octave <= octave + 1'b1;
              end
            end else begin
              operation <= 1'b1;
            end
          end else begin
            bin <= bin + 1'b1;
          end
        end
        S_DONE: begin
          finishedProcessing <= 1'b0;
          ready              <= 1'b1;
          r_state            <= S_IDLE;
        end
        default: begin
          r_state            <= S_IDLE;
          ready              <= 1'b1;
          writeSample        <= 1'b0;
          finishedProcessing <= 1'b0;
          octave             <= '0;
          bin                <= '0;
          operation          <= 1'b0;
        end
      endcase
    end
  end

  // Decimation selector advances once per stored sample and wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= '0;
    end else if (writeSample) begin
      r_sel <= r_sel + 1'b1;
    end
  end

  // Octave k is enabled when the low k selector bits are all zero (every 2^k samples)
  generate
    for (genvar k = 0; k < OCT; k++) begin : g_en
      if (k == 0) begin : g_base
        assign enableOctaves[k] = 1'b1;
      end else begin : g_dec
        assign enableOctaves[k] = (r_sel[k-1:0] == '0);
      end
    end
  endgenerate

  // One independent shift register per octave, entry 0 newest
  generate
    for (genvar k = 0; k < OCT; k++) begin : g_oct
      logic signed [N-1:0] r_line [SIZE];

      // Shift in the new sample only on a write that enables this octave
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SIZE; i++) r_line[i] <= '0;
        end else if (writeSample && enableOctaves[k]) begin
          r_line[0] <= newSample;
          for (int i = 1; i < SIZE; i++) r_line[i] <= r_line[i-1];
        end
      end

      assign w_tap0[k] = r_line[0];
      assign w_tap1[k] = r_line[1];
      assign w_tapo[k] = r_line[SIZE-1];
    end
  endgenerate

  // Combinational tap mux driven by the current octave index
  always_comb begin
    sample0      = '0;
    sample1      = '0;
    oldestSample = '0;
    for (int k = 0; k < OCT; k++) begin
      if (octave == c_OW'(k)) begin
        sample0      = w_tap0[k];
        sample1      = w_tap1[k];
        oldestSample = w_tapo[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dft_octave_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_dft_octave_control
// Description : Self-checking bench for dft_octave_control against a simple
//               array model of the delay lines and slot ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dft_octave_control;

  localparam int OCT  = 5;
  localparam int BINS = 24;
  localparam int N    = 16;
  localparam int SIZE = 8;
  localparam int SLOTS = 2 * OCT * BINS;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     sampleReady;
  logic signed [N-1:0]      newSample;
  logic                     ready;
  logic                     writeSample;
  logic [$clog2(OCT)-1:0]   octave;
  logic                     operation;
  logic [$clog2(BINS)-1:0]  bin;
  logic                     finishedProcessing;
  logic [OCT-1:0]           enableOctaves;
  logic signed [N-1:0]      sample0;
  logic signed [N-1:0]      sample1;
  logic signed [N-1:0]      oldestSample;

  int errors = 0;
  int checks = 0;

  // Reference model: per-octave histories and a count of stored samples
  logic signed [N-1:0] mdl [OCT][SIZE];
  int nwr;

  logic signed [N-1:0] cap0_s0, cap0_s1, cap0_old, cap1_s0, cap1_s1;

  dft_octave_control #(.OCT(OCT), .BINS(BINS), .N(N), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .sampleReady(sampleReady), .newSample(newSample),
    .ready(ready), .writeSample(writeSample), .octave(octave),
    .operation(operation), .bin(bin), .finishedProcessing(finishedProcessing),
    .enableOctaves(enableOctaves), .sample0(sample0), .sample1(sample1),
    .oldestSample(oldestSample)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Octave k is due when the sample index (mod 2^(OCT-1)) is a multiple of 2^k
  function automatic logic [OCT-1:0] exp_mask(input int n);
    int c;
    c = n % (1 << (OCT - 1));
    for (int k = 0; k < OCT; k++) exp_mask[k] = ((c % (1 << k)) == 0);
  endfunction

  task automatic model_reset();
    nwr = 0;
    for (int k = 0; k < OCT; k++)
      for (int i = 0; i < SIZE; i++) mdl[k][i] = '0;
  endtask

  task automatic model_write(input logic signed [N-1:0] v);
    logic [OCT-1:0] m;
    m = exp_mask(nwr);
    for (int k = 0; k < OCT; k++) begin
      if (m[k]) begin
        for (int i = SIZE - 1; i > 0; i--) mdl[k][i] = mdl[k][i-1];
        mdl[k][0] = v;
      end
    end
    nwr++;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_flags"}, {ready, writeSample, finishedProcessing}, 3'b100);
    chk({tag, "_slot"}, {octave, operation, bin}, '0);
    chk({tag, "_mask"}, enableOctaves, exp_mask(nwr));
    chk({tag, "_s0"}, sample0, mdl[0][0]);
    chk({tag, "_s1"}, sample1, mdl[0][1]);
    chk({tag, "_old"}, oldestSample, mdl[0][SIZE-1]);
  endtask

  // One full handshake; called at a negedge while the DUT is idle
  task automatic run_sample(input logic signed [N-1:0] v, input bit hold);
    int eo, eop, eb;
    sampleReady = 1'b1;
    newSample   = v;
    @(negedge clk);
    chk("write_flags", {ready, writeSample, finishedProcessing}, 3'b010);
    chk("write_mask", enableOctaves, exp_mask(nwr));
    model_write(v);
    if (!hold) sampleReady = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      @(negedge clk);
      newSample = N'($urandom);
      eo  = s / (2 * BINS);
      eop = (s / BINS) % 2;
      eb  = s % BINS;
      chk("proc_flags", {ready, writeSample, finishedProcessing}, 3'b000);
      chk("proc_oct", octave, eo);
      chk("proc_op", operation, eop);
      chk("proc_bin", bin, eb);
      chk("proc_s0", sample0, mdl[eo][0]);
      chk("proc_s1", sample1, mdl[eo][1]);
      chk("proc_old", oldestSample, mdl[eo][SIZE-1]);
      if (s == 0) begin
        cap0_s0 = sample0; cap0_s1 = sample1; cap0_old = oldestSample;
      end
      if (s == 2 * BINS) begin
        cap1_s0 = sample0; cap1_s1 = sample1;
      end
    end
    @(negedge clk);
    chk("done_flags", {ready, writeSample, finishedProcessing}, 3'b001);
    chk("done_slot", {octave, operation, bin}, '0);
    @(negedge clk);
    check_idle("after_done");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic signed [N-1:0] v;
    bit hold;
    int gap;

    rst = 1'b1; sampleReady = 1'b0; newSample = '0;
    model_reset();
    do_reset();
    check_idle("reset");
    chk("reset_mask_all", enableOctaves, 5'b11111);

    // Directed octave-0 storage
    run_sample(16'sd100, 1'b0);
    run_sample(16'sd222, 1'b1);
    run_sample(-16'sd333, 1'b0);
    chk("oct0_s0_dir", cap0_s0, -16'sd333);
    chk("oct0_s1_dir", cap0_s1, 16'sd222);

    // Idle cycles: no write, taps and selector unchanged
    repeat (4) begin
      @(negedge clk);
      check_idle("idle_hold");
    end

    for (int i = 0; i < 5; i++) run_sample(N'($urandom), 1'($urandom_range(0, 1)));
    chk("oct0_oldest_dir", cap0_old, 16'sd100);

    // Octave-1 decimation from a fresh reset
    do_reset();
    check_idle("reset2");
    run_sample(16'sd10, 1'b1);
    run_sample(16'sd20, 1'b1);
    run_sample(16'sd30, 1'b0);
    run_sample(16'sd40, 1'b0);
    chk("oct1_s0_dir", cap1_s0, 16'sd30);
    chk("oct1_s1_dir", cap1_s1, 16'sd10);

    // Randomized samples, holds and gaps (exercises selector wrap)
    for (int i = 0; i < 16; i++) begin
      v    = N'($urandom);
      hold = 1'($urandom_range(0, 1));
      run_sample(v, hold);
      if (!hold) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_idle("gap");
        end
      end
    end

    // Reset in the middle of PROCESS aborts without a finish pulse
    sampleReady = 1'b1;
    newSample   = 16'sd777;
    @(negedge clk);
    chk("abort_write", writeSample, 1'b1);
    sampleReady = 1'b0;
    repeat (50) @(negedge clk);
    chk("abort_busy", ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_idle("abort_reset");
    chk("abort_mask_all", enableOctaves, 5'b11111);
    repeat (3) begin
      @(negedge clk);
      check_idle("abort_after");
    end

    run_sample(-16'sd5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
